// File: rtl/dual_port_reg_file_if.sv
// Bus bundle for dual_port_reg_file: two write ports, two read ports, collision flag and write counter.
interface dual_port_reg_file_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = 8;

    logic              wr_en0;
    logic [ADDR_W-1:0] wr_addr0;
    logic [WIDTH-1:0]  wr_data0;
    logic              wr_en1;
    logic [ADDR_W-1:0] wr_addr1;
    logic [WIDTH-1:0]  wr_data1;
    logic [ADDR_W-1:0] rd_addr0;
    logic [WIDTH-1:0]  rd_data0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [WIDTH-1:0]  rd_data1;
    logic              wr_collision;
    logic [CNT_W-1:0]  wr_count;

    modport master (
        output wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1, rd_addr0, rd_addr1,
        input  rd_data0, rd_data1, wr_collision, wr_count
    );

    modport slave (
        input  wr_en0, wr_addr0, wr_data0, wr_en1, wr_addr1, wr_data1, rd_addr0, rd_addr1,
        output rd_data0, rd_data1, wr_collision, wr_count
    );
endinterface

// File: rtl/dual_port_reg_file.sv
// Parametrised 2-write/2-read register file; port 1 wins same-address collisions.
// Optional macro REG_FILE_BYPASS_EN enables write-first forwarding onto the read ports.
module dual_port_reg_file #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 8,
    parameter bit          ZERO_REG = 1'b0
) (
    input logic                 clk_i,
    input logic                 rst_i,
    dual_port_reg_file_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = 8;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic             collision_q, collision_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             we0_c, we1_c;

    // Address holds a writable, readable register (in range and not the hard-wired zero).
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
    endfunction

    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] ra);
        logic [WIDTH-1:0] v;
        v = '0;
        if (addr_ok(ra)) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ADDR_W'(i) == ra) v = regs_q[i];
            end
        end
`ifdef REG_FILE_BYPASS_EN
        if (we1_c && (bus.wr_addr1 == ra)) v = bus.wr_data1;
        else if (we0_c && (bus.wr_addr0 == ra)) v = bus.wr_data0;
`endif
        return v;
    endfunction

    // Next-state: port 1 is applied after port 0 so it overrides on a shared address.
    always_comb begin
        regs_d      = regs_q;
        count_d     = count_q;
        we0_c       = bus.wr_en0 && addr_ok(bus.wr_addr0);
        we1_c       = bus.wr_en1 && addr_ok(bus.wr_addr1);
        collision_d = bus.wr_en0 && bus.wr_en1 && (bus.wr_addr0 == bus.wr_addr1)
                      && (32'(bus.wr_addr0) < DEPTH);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (we0_c && (bus.wr_addr0 == ADDR_W'(i))) regs_d[i] = bus.wr_data0;
            if (we1_c && (bus.wr_addr1 == ADDR_W'(i))) regs_d[i] = bus.wr_data1;
        end
        if ((we0_c || we1_c) && (count_q != '1)) count_d = count_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
            collision_q <= 1'b0;
            count_q     <= '0;
        end else begin
            regs_q      <= regs_d;
            collision_q <= collision_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        bus.rd_data0     = read_port(bus.rd_addr0);
        bus.rd_data1     = read_port(bus.rd_addr1);
        bus.wr_collision = collision_q;
        bus.wr_count     = count_q;
    end
endmodule

// File: tb/tb_dual_port_reg_file.sv
// Bench for dual_port_reg_file: a DEPTH=8 instance and a DEPTH=6/ZERO_REG=1 instance share stimulus.
module tb_dual_port_reg_file;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        en0, en1;
    logic [2:0]  a0, a1, ra0, ra1;
    logic [15:0] d0, d1;

    dual_port_reg_file_if #(.WIDTH(16), .DEPTH(8)) bus_a ();
    dual_port_reg_file_if #(.WIDTH(16), .DEPTH(6)) bus_b ();

    dual_port_reg_file #(.WIDTH(16), .DEPTH(8), .ZERO_REG(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(bus_a));
    dual_port_reg_file #(.WIDTH(16), .DEPTH(6), .ZERO_REG(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(bus_b));

    assign bus_a.wr_en0 = en0;  assign bus_a.wr_addr0 = a0;  assign bus_a.wr_data0 = d0;
    assign bus_a.wr_en1 = en1;  assign bus_a.wr_addr1 = a1;  assign bus_a.wr_data1 = d1;
    assign bus_a.rd_addr0 = ra0; assign bus_a.rd_addr1 = ra1;
    assign bus_b.wr_en0 = en0;  assign bus_b.wr_addr0 = a0;  assign bus_b.wr_data0 = d0;
    assign bus_b.wr_en1 = en1;  assign bus_b.wr_addr1 = a1;  assign bus_b.wr_data1 = d1;
    assign bus_b.rd_addr0 = ra0; assign bus_b.rd_addr1 = ra1;

    logic [15:0] rd0 [2];
    logic [15:0] rd1 [2];
    logic        col_o [2];
    logic [7:0]  cnt_o [2];
    assign rd0[0] = bus_a.rd_data0; assign rd1[0] = bus_a.rd_data1;
    assign rd0[1] = bus_b.rd_data0; assign rd1[1] = bus_b.rd_data1;
    assign col_o[0] = bus_a.wr_collision; assign cnt_o[0] = bus_a.wr_count;
    assign col_o[1] = bus_b.wr_collision; assign cnt_o[1] = bus_b.wr_count;

    // Reference model: plain arrays per instance.
    int          dep [2] = '{8, 6};
    bit          zr  [2] = '{1'b0, 1'b1};
    logic [15:0] mem [2][8];
    int          cnt [2];
    bit          col [2];

    int errors = 0;
    int checks = 0;

    function automatic bit ok(input int k, input int a);
        return (a < dep[k]) && !(zr[k] && a == 0);
    endfunction

    function automatic logic [15:0] exp_rd(input int k, input int ra);
`ifdef REG_FILE_BYPASS_EN
        if (en1 && ok(k, int'(a1)) && int'(a1) == ra) return d1;
        if (en0 && ok(k, int'(a0)) && int'(a0) == ra) return d0;
`endif
        return ok(k, ra) ? mem[k][ra] : 16'h0000;
    endfunction

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got=%h want=%h at %0t", nm, k, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        bit any;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 8; i++) mem[k][i] = 16'h0000;
                cnt[k] = 0;
                col[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                any = 1'b0;
                col[k] = en0 && en1 && (a0 == a1) && (int'(a0) < dep[k]);
                if (en0 && ok(k, int'(a0))) begin mem[k][a0] = d0; any = 1'b1; end
                if (en1 && ok(k, int'(a1))) begin mem[k][a1] = d1; any = 1'b1; end
                if (any && cnt[k] < 255) cnt[k]++;
            end
        end
    end

    // Every cycle, after inputs settle, compare all outputs to the model.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                chk("rd_data0", k, rd0[k], exp_rd(k, int'(ra0)));
                chk("rd_data1", k, rd1[k], exp_rd(k, int'(ra1)));
                chk("wr_collision", k, col_o[k], col[k]);
                chk("wr_count", k, cnt_o[k], cnt[k]);
            end
        end
    end

    task automatic drive(input logic e0, input logic [2:0] aa0, input logic [15:0] dd0,
                         input logic e1, input logic [2:0] aa1, input logic [15:0] dd1,
                         input logic [2:0] r0, input logic [2:0] r1);
        @(negedge clk);
        en0 = e0; a0 = aa0; d0 = dd0;
        en1 = e1; a1 = aa1; d1 = dd1;
        ra0 = r0; ra1 = r1;
    endtask

    task automatic idle(input logic [2:0] r0, input logic [2:0] r1);
        drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, r0, r1);
    endtask

    initial begin
        logic [2:0] ra;
        en0 = 1'b0; en1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0; ra0 = '0; ra1 = '0;
        #1 rst = 1'b1;
        #2;
        chk("reset_count", 0, cnt_o[0], 0);
        chk("reset_collision", 1, col_o[1], 0);
        @(negedge clk); rst = 1'b0;

        // Async reset between edges wipes a committed write.
        drive(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 16'h0, 3'd3, 3'd3);
        idle(3'd3, 3'd3); #3;
        chk("beef_written", 0, rd0[0], 16'hBEEF);
        rst = 1'b1; #1;
        chk("async_reset_data", 0, rd0[0], 16'h0000);
        chk("async_reset_count", 0, cnt_o[0], 0);
        @(negedge clk); rst = 1'b0;

        drive(1'b1, 3'd2, 16'h1111, 1'b1, 3'd5, 16'h2222, 3'd2, 3'd5);
        idle(3'd2, 3'd5); #3;
        chk("dual_rd2", 0, rd0[0], 16'h1111);
        chk("dual_rd5", 0, rd1[0], 16'h2222);
        chk("dual_nocol", 0, col_o[0], 0);
        chk("dual_count", 0, cnt_o[0], 1);
        chk("dual_rd5_b", 1, rd1[1], 16'h2222);

        drive(1'b1, 3'd4, 16'hAAAA, 1'b1, 3'd4, 16'h5555, 3'd4, 3'd4);
        idle(3'd4, 3'd4); #3;
        chk("col_winner", 0, rd0[0], 16'h5555);
        chk("col_flag", 0, col_o[0], 1);
        chk("col_count", 0, cnt_o[0], 2);
        idle(3'd4, 3'd4); #3;
        chk("col_drop", 0, col_o[0], 0);

        drive(1'b1, 3'd6, 16'h1234, 1'b0, 3'd0, 16'h0, 3'd6, 3'd6); #3;
`ifdef REG_FILE_BYPASS_EN
        chk("bypass_same_cycle", 0, rd0[0], 16'h1234);
`else
        chk("bypass_same_cycle", 0, rd0[0], 16'h0000);
`endif
        chk("bypass_oor", 1, rd0[1], 16'h0000);
        idle(3'd6, 3'd6); #3;
        chk("bypass_next_cycle", 0, rd0[0], 16'h1234);

        // Zero register and out-of-range addresses on the DEPTH=6 instance.
        drive(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd7, 16'hFFFF, 3'd0, 3'd7); #3;
        chk("zero_nobypass", 1, rd0[1], 16'h0000);
        idle(3'd0, 3'd7); #3;
        chk("zero_rd", 1, rd0[1], 16'h0000);
        chk("oor_rd", 1, rd1[1], 16'h0000);
        chk("zero_count", 1, cnt_o[1], 2);
        chk("full_count", 0, cnt_o[0], 4);
        drive(1'b1, 3'd0, 16'h0001, 1'b1, 3'd0, 16'h0002, 3'd0, 3'd0);
        idle(3'd0, 3'd0); #3;
        chk("zero_col_flag", 1, col_o[1], 1);
        chk("zero_col_count", 1, cnt_o[1], 2);

        repeat (400) begin
            ra = 3'($urandom_range(0, 7));
            drive(1'($urandom), 3'($urandom), 16'($urandom),
                  1'($urandom), ($urandom_range(0, 3) == 0) ? ra : 3'($urandom), 16'($urandom),
                  3'($urandom), 3'($urandom));
            if ($urandom_range(0, 3) == 0) a0 = a1;
        end

        repeat (300) drive(1'b1, 3'($urandom), 16'($urandom),
                           1'b1, 3'($urandom_range(1, 5)), 16'($urandom),
                           3'($urandom), 3'($urandom));
        idle(3'd1, 3'd2); #3;
        chk("sat_a", 0, cnt_o[0], 255);
        chk("sat_b", 1, cnt_o[1], 255);
        repeat (3) drive(1'b1, 3'd1, 16'h7, 1'b0, 3'd0, 16'h0, 3'd1, 3'd2);
        idle(3'd1, 3'd2); #3;
        chk("sat_hold", 0, cnt_o[0], 255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
